// File: rtl/zx_ps2_keyboard.sv
// zx_ps2_keyboard
// PS/2 set-2 keyboard receiver and decoder that holds a ZX80/ZX81 8x5 key
// matrix for the ULA to read during port-FE input cycles.
// Ports:
//   clk_sys, reset_n          system clock, async active-low reset
//   ps2_kbd_clk, ps2_kbd_data PS/2 lines (asynchronous, clock idles high)
//   addr[7:0]                 Z80 A[15:8]; a 0 bit selects that half-row
//   key_data[4:0]             active-low columns of the selected rows
//   reset_req                 high while F12 is held
//   rx_byte, rx_strobe        last good byte and its one-cycle update pulse
//   frame_err                 one-cycle pulse on parity/stop/timeout error
module zx_ps2_keyboard #(
  parameter int FILT    = 4,
  parameter int TIMEOUT = 8192
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_kbd_clk,
  input  logic       ps2_kbd_data,
  input  logic [7:0] addr,
  output logic [4:0] key_data,
  output logic       reset_req,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       frame_err
);
  localparam int FCW = $clog2(FILT + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  // ---- input conditioning ----
  logic [1:0]     clk_s, dat_s;
  logic           clk_f, clk_fd;
  logic [FCW-1:0] filt_cnt;
  logic           samp, dat;

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      clk_s    <= 2'b11;
      dat_s    <= 2'b11;
      clk_f    <= 1'b1;
      clk_fd   <= 1'b1;
      filt_cnt <= '0;
    end else begin
      clk_s  <= {clk_s[0], ps2_kbd_clk};
      dat_s  <= {dat_s[0], ps2_kbd_data};
      clk_fd <= clk_f;
      if (clk_s[1] != clk_f) begin
        if (filt_cnt == FCW'(FILT - 1)) begin
          clk_f    <= clk_s[1];
          filt_cnt <= '0;
        end else filt_cnt <= filt_cnt + 1'b1;
      end else filt_cnt <= '0;
    end

  assign samp = clk_fd & ~clk_f;
  assign dat  = dat_s[1];

  // ---- receiver FSM ----
  rx_state_t   state, state_n;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        par;
  logic [15:0] to_cnt;
  logic        good, bad;

  always_comb begin
    state_n = state;
    good    = 1'b0;
    bad     = 1'b0;
    if (state != RX_IDLE && !samp && to_cnt == 16'(TIMEOUT - 1)) begin
      state_n = RX_IDLE;
      bad     = 1'b1;
    end else if (samp) begin
      case (state)
        RX_IDLE:   if (!dat) state_n = RX_DATA;
        RX_DATA:   if (bit_cnt == 3'd7) state_n = RX_PARITY;
        RX_PARITY: state_n = RX_STOP;
        RX_STOP: begin
          state_n = RX_IDLE;
          // odd parity: data ones plus parity bit must be odd
          if ((^shreg ^ par) && dat) good = 1'b1;
          else                       bad  = 1'b1;
        end
        default:   state_n = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      state     <= RX_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      to_cnt    <= '0;
      rx_byte   <= '0;
      rx_strobe <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      rx_strobe <= good;
      frame_err <= bad;
      if (good) rx_byte <= shreg;
      to_cnt <= (state == RX_IDLE || samp) ? 16'd0 : to_cnt + 16'd1;
      if (samp) begin
        case (state)
          RX_IDLE:   bit_cnt <= '0;
          RX_DATA: begin
            shreg   <= {dat, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          RX_PARITY: par <= dat;
          default: ;
        endcase
      end
    end

  // ---- scan-code decoder ----
  // {hit, row, col} for plain (non-extended) single-key codes; SHIFT handled apart
  function automatic logic [6:0] key_map(input logic [7:0] c);
    case (c)
      8'h1A: return {1'b1, 3'd0, 3'd1};  8'h22: return {1'b1, 3'd0, 3'd2};
      8'h21: return {1'b1, 3'd0, 3'd3};  8'h2A: return {1'b1, 3'd0, 3'd4};
      8'h1C: return {1'b1, 3'd1, 3'd0};  8'h1B: return {1'b1, 3'd1, 3'd1};
      8'h23: return {1'b1, 3'd1, 3'd2};  8'h2B: return {1'b1, 3'd1, 3'd3};
      8'h34: return {1'b1, 3'd1, 3'd4};
      8'h15: return {1'b1, 3'd2, 3'd0};  8'h1D: return {1'b1, 3'd2, 3'd1};
      8'h24: return {1'b1, 3'd2, 3'd2};  8'h2D: return {1'b1, 3'd2, 3'd3};
      8'h2C: return {1'b1, 3'd2, 3'd4};
      8'h16: return {1'b1, 3'd3, 3'd0};  8'h1E: return {1'b1, 3'd3, 3'd1};
      8'h26: return {1'b1, 3'd3, 3'd2};  8'h25: return {1'b1, 3'd3, 3'd3};
      8'h2E: return {1'b1, 3'd3, 3'd4};
      8'h45: return {1'b1, 3'd4, 3'd0};  8'h46: return {1'b1, 3'd4, 3'd1};
      8'h3E: return {1'b1, 3'd4, 3'd2};  8'h3D: return {1'b1, 3'd4, 3'd3};
      8'h36: return {1'b1, 3'd4, 3'd4};
      8'h4D: return {1'b1, 3'd5, 3'd0};  8'h44: return {1'b1, 3'd5, 3'd1};
      8'h43: return {1'b1, 3'd5, 3'd2};  8'h3C: return {1'b1, 3'd5, 3'd3};
      8'h35: return {1'b1, 3'd5, 3'd4};
      8'h5A: return {1'b1, 3'd6, 3'd0};  8'h4B: return {1'b1, 3'd6, 3'd1};
      8'h42: return {1'b1, 3'd6, 3'd2};  8'h3B: return {1'b1, 3'd6, 3'd3};
      8'h33: return {1'b1, 3'd6, 3'd4};
      8'h29: return {1'b1, 3'd7, 3'd0};  8'h49: return {1'b1, 3'd7, 3'd1};
      8'h3A: return {1'b1, 3'd7, 3'd2};  8'h31: return {1'b1, 3'd7, 3'd3};
      8'h32: return {1'b1, 3'd7, 3'd4};
      default: return 7'd0;
    endcase
  endfunction

  logic [7:0][4:0] keys;    // direct key bits; keys[0][0] unused (SHIFT below)
  logic            lshift, rshift, f12, ext, rel;
  logic [4:0]      comp;    // BKSP, LEFT, DOWN, UP, RIGHT
  logic [6:0]      km;

  assign km = key_map(rx_byte);

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      keys <= '0; comp <= '0;
      lshift <= 1'b0; rshift <= 1'b0; f12 <= 1'b0;
      ext <= 1'b0; rel <= 1'b0;
    end else if (rx_strobe) begin
      case (rx_byte)
        8'hE0: ext <= 1'b1;
        8'hF0: rel <= 1'b1;
        8'hAA, 8'hFF: begin
          keys <= '0; comp <= '0;
          lshift <= 1'b0; rshift <= 1'b0; f12 <= 1'b0;
          ext <= 1'b0; rel <= 1'b0;
        end
        default: begin
          ext <= 1'b0;
          rel <= 1'b0;
          if (!ext) begin
            case (rx_byte)
              8'h12:   lshift  <= ~rel;
              8'h59:   rshift  <= ~rel;
              8'h07:   f12     <= ~rel;
              8'h66:   comp[0] <= ~rel;
              default: if (km[6]) keys[km[5:3]][km[2:0]] <= ~rel;
            endcase
          end else begin
            case (rx_byte)
              8'h6B:   comp[1] <= ~rel;
              8'h72:   comp[2] <= ~rel;
              8'h75:   comp[3] <= ~rel;
              8'h74:   comp[4] <= ~rel;
              default: ;
            endcase
          end
        end
      endcase
    end

  assign reset_req = f12;

  // ---- read path ----
  logic [7:0][4:0] eff;
  logic [4:0]      acc;

  always_comb begin
    eff        = keys;
    eff[0][0]  = lshift | rshift | (|comp);
    eff[4][0]  = keys[4][0] | comp[0];   // 0 <- BKSP
    eff[3][4]  = keys[3][4] | comp[1];   // 5 <- LEFT
    eff[4][4]  = keys[4][4] | comp[2];   // 6 <- DOWN
    eff[4][3]  = keys[4][3] | comp[3];   // 7 <- UP
    eff[4][2]  = keys[4][2] | comp[4];   // 8 <- RIGHT
    acc = '0;
    for (int r = 0; r < 8; r++)
      if (!addr[r]) acc = acc | eff[r];
    key_data = ~acc;
  end
endmodule

// File: tb/tb_zx_ps2_keyboard.sv
// Directed bench for zx_ps2_keyboard: drives PS/2 frames and checks the
// decoded matrix, strobe/error pulses and reset behaviour.
module tb_zx_ps2_keyboard;
  localparam int TIMEOUT = 8192;

  logic       clk_sys = 0;
  logic       reset_n = 0;
  logic       ps2_kbd_clk = 1;
  logic       ps2_kbd_data = 1;
  logic [7:0] addr = 8'hFF;
  logic [4:0] key_data;
  logic       reset_req;
  logic [7:0] rx_byte;
  logic       rx_strobe;
  logic       frame_err;

  int errors = 0;
  int checks = 0;
  int strobe_cnt = 0, err_cnt = 0, run = 0, max_run = 0;
  int s0, e0;

  zx_ps2_keyboard #(.FILT(4), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ps2_kbd_clk(ps2_kbd_clk), .ps2_kbd_data(ps2_kbd_data),
    .addr(addr), .key_data(key_data), .reset_req(reset_req),
    .rx_byte(rx_byte), .rx_strobe(rx_strobe), .frame_err(frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  // pulse monitor, sampled away from the active edge
  always @(negedge clk_sys) begin
    if (rx_strobe) begin strobe_cnt++; run++; end
    else run = 0;
    if (run > max_run) max_run = run;
    if (frame_err) err_cnt++;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [4:0] exp);
    @(negedge clk_sys);
    addr = a;
    #1;
    chk(tag, {3'b000, key_data}, {3'b000, exp});
  endtask

  task automatic ps2_bit(input logic b);
    repeat (10) @(negedge clk_sys);
    ps2_kbd_data = b;
    repeat (10) @(negedge clk_sys);
    ps2_kbd_clk = 0;
    repeat (20) @(negedge clk_sys);
    ps2_kbd_clk = 1;
  endtask

  task automatic send(input logic [7:0] b, input logic bad_par = 0, input logic stop = 1);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(stop);
    ps2_kbd_data = 1;
    repeat (20) @(negedge clk_sys);
  endtask

  initial begin
    repeat (5) @(negedge clk_sys);
    // reset state
    addr = 8'h00; #1;
    chk("rst_key_all", {3'b0, key_data}, 8'h1F);
    chk("rst_req", {7'b0, reset_req}, 8'h00);
    chk("rst_rx_byte", rx_byte, 8'h00);
    chk("rst_strobe", {7'b0, rx_strobe}, 8'h00);
    chk("rst_ferr", {7'b0, frame_err}, 8'h00);
    reset_n = 1;
    repeat (5) @(negedge clk_sys);

    // Z press
    s0 = strobe_cnt; e0 = err_cnt;
    send(8'h1A);
    chk("z_rx_byte", rx_byte, 8'h1A);
    chk("z_strobe_cnt", 8'(strobe_cnt - s0), 8'd1);
    chk("z_strobe_width", 8'(max_run), 8'd1);
    rd("z_row0", 8'hFE, 5'b11101);
    rd("z_row1", 8'hFD, 5'h1F);
    send(8'hF0); send(8'h1A);
    rd("z_release", 8'hFE, 5'h1F);

    // A + Q, then AA clears everything
    send(8'h1C); send(8'h15);
    rd("aq_rows12", 8'hF9, 5'b11110);
    send(8'hAA);
    rd("aa_clear", 8'hF9, 5'h1F);

    // LEFT composite = SHIFT + 5
    send(8'hE0); send(8'h6B);
    rd("left_row3", 8'hF7, 5'b01111);
    rd("left_shift", 8'hFE, 5'b11110);
    send(8'h12);
    send(8'hE0); send(8'hF0); send(8'h6B);
    rd("lshift_held", 8'hFE, 5'b11110);
    rd("left_rel_row3", 8'hF7, 5'h1F);
    send(8'hF0); send(8'h12);
    rd("shift_rel", 8'hFE, 5'h1F);

    // extended variant of a plain code is ignored
    send(8'hE0); send(8'h1A);
    rd("ext_1a_ignored", 8'hFE, 5'h1F);

    // bad parity, then bad stop bit
    s0 = strobe_cnt; e0 = err_cnt;
    send(8'h1C, 1'b1, 1'b1);
    chk("par_ferr", 8'(err_cnt - e0), 8'd1);
    chk("par_no_strobe", 8'(strobe_cnt - s0), 8'd0);
    rd("par_keys", 8'hFD, 5'h1F);
    send(8'h1C, 1'b0, 1'b0);
    chk("stop_ferr", 8'(err_cnt - e0), 8'd2);
    chk("stop_no_strobe", 8'(strobe_cnt - s0), 8'd0);
    chk("err_rx_byte", rx_byte, 8'h1A);
    rd("stop_keys", 8'hFD, 5'h1F);

    // ext survives a dropped byte
    send(8'hE0); send(8'h11, 1'b1, 1'b1); send(8'h6B);
    rd("ext_persist", 8'hF7, 5'b01111);
    send(8'hE0); send(8'hF0); send(8'h6B);
    rd("ext_persist_rel", 8'hF7, 5'h1F);

    // timeout mid-frame
    e0 = err_cnt; s0 = strobe_cnt;
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    ps2_kbd_data = 1;
    repeat (TIMEOUT + 10) @(negedge clk_sys);
    chk("timeout_ferr", 8'(err_cnt - e0), 8'd1);
    chk("timeout_no_strobe", 8'(strobe_cnt - s0), 8'd0);
    send(8'h1C);
    rd("after_timeout", 8'hFD, 5'b11110);
    send(8'hF0); send(8'h1C);

    // F12 reset request
    send(8'h07);
    chk("f12_press", {7'b0, reset_req}, 8'h01);
    send(8'hF0); send(8'h07);
    chk("f12_release", {7'b0, reset_req}, 8'h00);

    // reset mid-frame with keys held
    send(8'h07); send(8'h1A);
    chk("pre_rst_req", {7'b0, reset_req}, 8'h01);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1); ps2_bit(1'b0);
    @(negedge clk_sys);
    reset_n = 0; addr = 8'h00; #1;
    chk("mid_rst_keys", {3'b0, key_data}, 8'h1F);
    chk("mid_rst_req", {7'b0, reset_req}, 8'h00);
    chk("mid_rst_rx_byte", rx_byte, 8'h00);
    chk("mid_rst_strobe", {7'b0, rx_strobe}, 8'h00);
    ps2_kbd_clk = 1; ps2_kbd_data = 1;
    repeat (10) @(negedge clk_sys);
    reset_n = 1;
    repeat (5) @(negedge clk_sys);
    send(8'h15);
    chk("post_rst_byte", rx_byte, 8'h15);
    rd("post_rst_q", 8'hFB, 5'b11110);
    rd("post_rst_z_gone", 8'hFE, 5'h1F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
